// File: rtl/stack_sequencer_if.sv
// stack_sequencer_if: decode-stage requests, pipeline control and stack-memory port of the stack sequencer.
interface stack_sequencer_if #(parameter int W = 16);
  logic         interrupt;
  logic         op_call;
  logic         op_ret;
  logic         op_reti;
  logic         hold;
  logic [W-1:0] pc_ret;
  logic [2:0]   flags_in;
  logic [W-1:0] mem_rdata;
  logic [W-1:0] mem_addr;
  logic [W-1:0] mem_wdata;
  logic         mem_we;
  logic         mem_re;
  logic         flags_wr;
  logic [2:0]   flags_out;
  logic         pc_enable;
  logic         fd_enable;
  logic         flush;
  logic [1:0]   jump_sel;
  logic [W-1:0] sp;
  logic [W-1:0] pop_data;
  logic         busy;
  modport master (
    output interrupt, op_call, op_ret, op_reti, hold, pc_ret, flags_in, mem_rdata,
    input  mem_addr, mem_wdata, mem_we, mem_re, flags_wr, flags_out, pc_enable, fd_enable,
           flush, jump_sel, sp, pop_data, busy
  );
  modport slave (
    input  interrupt, op_call, op_ret, op_reti, hold, pc_ret, flags_in, mem_rdata,
    output mem_addr, mem_wdata, mem_we, mem_re, flags_wr, flags_out, pc_enable, fd_enable,
           flush, jump_sel, sp, pop_data, busy
  );
endinterface

// File: rtl/stack_sequencer.sv
// stack_sequencer: one FSM sequencing CALL/RET/RETI/interrupt entry over the data-memory port.
// Owns the stack pointer; the stack grows down and SP addresses the next free word.
module stack_sequencer #(
  parameter int           W        = 16,
  parameter logic [W-1:0] SP_RESET = 16'h07FF
) (
  input logic              clk,
  input logic              rst_n,
  stack_sequencer_if.slave bus
);
  typedef enum logic [3:0] {IDLE, C_PUSH, R_POP, RI_FLG, RI_PC, R_LOAD, I_PC, I_FLG, I_VEC} state_t;
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};
  state_t       state_q, state_d;
  logic [W-1:0] sp_q, sp_d, pc_q, pc_d, pop_q, pop_d, pop_data, push_data;
  logic [2:0]   flg_q, flg_d;
  logic         pend_q, pend_d, fresh_q;
  logic         idle, any_op, go, int_go, push, pop, redir;
  logic [1:0]   jsel;
  assign idle   = state_q == IDLE;
  assign any_op = bus.op_call | bus.op_ret | bus.op_reti;
  assign go     = idle & !bus.hold & (any_op | pend_q);
  assign int_go = go & !any_op;
  always_comb begin
    state_d   = state_q;
    push      = 1'b0;
    pop       = 1'b0;
    redir     = 1'b0;
    jsel      = 2'b00;
    push_data = pc_q;
    case (state_q)
      IDLE:    state_d = !go ? IDLE : bus.op_call ? C_PUSH : bus.op_ret ? R_POP :
                         bus.op_reti ? RI_FLG : I_PC;
      C_PUSH:  begin push = 1'b1; redir = 1'b1; jsel = 2'b01; state_d = IDLE; end
      R_POP:   begin pop = 1'b1; state_d = R_LOAD; end
      RI_FLG:  begin pop = 1'b1; state_d = RI_PC; end
      RI_PC:   begin pop = 1'b1; state_d = R_LOAD; end
      R_LOAD:  begin redir = 1'b1; jsel = 2'b10; state_d = IDLE; end
      I_PC:    begin push = 1'b1; state_d = I_FLG; end
      I_FLG:   begin push = 1'b1; push_data = {{(W-3){1'b0}}, flg_q}; state_d = I_VEC; end
      I_VEC:   begin redir = 1'b1; jsel = 2'b11; state_d = IDLE; end
      default: state_d = IDLE;
    endcase
    if (bus.hold) state_d = state_q;
  end
  // Popped word is live on mem_rdata only in the cycle after the read; a hold keeps it in pop_q.
  assign pop_data = fresh_q ? bus.mem_rdata : pop_q;
  assign pop_d    = pop_data;
  assign pc_d     = go ? bus.pc_ret : pc_q;
  assign flg_d    = go ? bus.flags_in : flg_q;
  assign pend_d   = bus.interrupt | (pend_q & !int_go);
  assign sp_d     = bus.hold ? sp_q : push ? sp_q - ONE : pop ? sp_q + ONE : sp_q;
  assign bus.mem_addr  = pop ? sp_q + ONE : sp_q;
  assign bus.mem_wdata = push_data;
  assign bus.mem_we    = push & !bus.hold;
  assign bus.mem_re    = pop & !bus.hold;
  assign bus.flags_wr  = (state_q == RI_PC) & !bus.hold;
  assign bus.flags_out = pop_data[2:0];
  assign bus.pop_data  = pop_data;
  assign bus.jump_sel  = jsel;
  assign bus.flush     = redir & !bus.hold;
  assign bus.pc_enable = !rst_n | (!bus.hold & (idle ? !go : redir));
  assign bus.fd_enable = bus.pc_enable;
  assign bus.busy      = rst_n & (!idle | go);
  assign bus.sp        = sp_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      sp_q    <= SP_RESET;
      pc_q    <= '0;
      pop_q   <= '0;
      flg_q   <= '0;
      pend_q  <= 1'b0;
      fresh_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      pc_q    <= pc_d;
      pop_q   <= pop_d;
      flg_q   <= flg_d;
      pend_q  <= pend_d;
      fresh_q <= bus.mem_re;
    end
endmodule

// File: tb/tb_stack_sequencer.sv
// tb_stack_sequencer: randomized CALL/RET/RETI/INT sequences checked against a transaction-level stack model.
module tb_stack_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  stack_sequencer_if #(.W(16)) bus ();
  stack_sequencer #(.W(16), .SP_RESET(16'h07FF)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int checks = 0;
  int failures = 0;
  logic [15:0] mem [0:65535];
  logic [15:0] ref_mem [0:65535];
  logic [15:0] m_sp;
  logic        m_pend;
  logic [31:0] wq[$];
  logic [15:0] rq[$];
  logic [2:0]  fq[$];
  logic        o_busy, o_pce, o_fde, o_flush, o_we, o_re, o_fwr;
  logic [1:0]  o_js;
  logic [15:0] o_pop;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    logic we, re;
    logic [15:0] a, d;
    #1;
    we = bus.mem_we; re = bus.mem_re; a = bus.mem_addr; d = bus.mem_wdata;
    o_busy = bus.busy; o_pce = bus.pc_enable; o_fde = bus.fd_enable; o_flush = bus.flush;
    o_we = we; o_re = re; o_fwr = bus.flags_wr; o_js = bus.jump_sel; o_pop = bus.pop_data;
    if (we) wq.push_back({a, d});
    if (re) rq.push_back(a);
    if (bus.flags_wr) fq.push_back(bus.flags_out);
    if (bus.interrupt && rst_n) m_pend = 1'b1;
    @(posedge clk);
    #1;
    if (we) mem[a] = d;
    bus.mem_rdata = re ? mem[a] : 16'($urandom);
    @(negedge clk);
  endtask
  task automatic run_op(input int kind, input logic [15:0] pc, input logic [2:0] f,
                        input int hmode, input bit irq_acc);
    logic [31:0] ew[$];
    logic [15:0] er[$];
    logic [2:0]  ef[$];
    logic [15:0] a1, a2, epop;
    logic [1:0]  ejs;
    int base, k, holds;
    bit done;
    a1 = m_sp + 16'd1; a2 = m_sp + 16'd2; epop = '0;
    case (kind)
      0: begin ew.push_back({m_sp, pc}); ref_mem[m_sp] = pc; m_sp = m_sp - 16'd1; ejs = 2'b01; base = 2; end
      1: begin er.push_back(a1); epop = ref_mem[a1]; m_sp = a1; ejs = 2'b10; base = 3; end
      2: begin
        er.push_back(a1); er.push_back(a2); ef.push_back(ref_mem[a1][2:0]);
        epop = ref_mem[a2]; m_sp = a2; ejs = 2'b10; base = 4;
      end
      default: begin
        ew.push_back({m_sp, pc}); ew.push_back({m_sp - 16'd1, 13'd0, f});
        ref_mem[m_sp] = pc; ref_mem[m_sp - 16'd1] = {13'd0, f};
        m_sp = m_sp - 16'd2; ejs = 2'b11; base = 4;
      end
    endcase
    bus.hold = 1'b0;
    if (kind == 3 && !m_pend) begin
      bus.interrupt = 1'b1;
      tick();
      chk("irq_pulse_busy", o_busy, 1'b0);
      bus.interrupt = 1'b0;
    end
    wq.delete(); rq.delete(); fq.delete();
    bus.pc_ret = pc; bus.flags_in = f;
    bus.op_call = kind == 0; bus.op_ret = kind == 1; bus.op_reti = kind == 2;
    bus.interrupt = irq_acc;
    if (kind == 3) m_pend = 1'b0;
    tick();
    chk("accept_busy", o_busy, 1'b1);
    chk("accept_en", {o_pce, o_fde}, 2'b00);
    bus.op_call = 1'b0; bus.op_ret = 1'b0; bus.op_reti = 1'b0; bus.interrupt = 1'b0;
    holds = 0; done = 1'b0; k = 0;
    while (!done && k < 40) begin
      k++;
      bus.pc_ret = 16'($urandom); bus.flags_in = 3'($urandom);
      bus.hold = hmode == 1 ? ($urandom_range(3) == 0) : hmode == 2 ? (k >= 2 && k <= 4) : 1'b0;
      bus.interrupt = hmode == 1 && $urandom_range(7) == 0;
      tick();
      if (bus.hold) begin
        holds++;
        chk("hold_quiet", {o_we, o_re, o_fwr, o_pce}, 4'b0);
        chk("hold_busy", o_busy, 1'b1);
      end else if (o_pce) begin
        done = 1'b1;
        chk("redir_js", o_js, ejs);
        chk("redir_flush", {o_flush, o_fde}, 2'b11);
        chk("latency", k + 1, base + holds);
        if (ejs == 2'b10) chk("ret_pc", o_pop, epop);
      end
    end
    bus.hold = 1'b0; bus.interrupt = 1'b0;
    if (!done) chk("redirect_timeout", 1'b0, 1'b1);
    chk("n_writes", wq.size(), ew.size());
    for (int i = 0; i < ew.size() && i < wq.size(); i++) chk("write", wq[i], ew[i]);
    chk("n_reads", rq.size(), er.size());
    for (int i = 0; i < er.size() && i < rq.size(); i++) chk("read_addr", rq[i], er[i]);
    chk("n_flag_wr", fq.size(), ef.size());
    for (int i = 0; i < ef.size() && i < fq.size(); i++) chk("flags_out", fq[i], ef[i]);
    chk("sp", bus.sp, m_sp);
    if (!m_pend) begin
      tick();
      chk("idle_busy", o_busy, 1'b0);
      chk("idle_en", {o_pce, o_fde, o_flush, o_js}, 5'b11000);
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_sp = 16'h07FF; m_pend = 1'b0;
  endtask
  initial begin
    int kind;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 16'(i * 13 + 5);
      ref_mem[i] = 16'(i * 13 + 5);
    end
    bus.interrupt = 1'b0; bus.op_call = 1'b1; bus.op_ret = 1'b0; bus.op_reti = 1'b0;
    bus.hold = 1'b1; bus.pc_ret = 16'h1234; bus.flags_in = 3'b111; bus.mem_rdata = '0;
    @(negedge clk);
    #1;
    chk("rst_sp", bus.sp, 16'h07FF);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_en", {bus.pc_enable, bus.fd_enable}, 2'b11);
    chk("rst_strobes", {bus.mem_we, bus.mem_re, bus.flags_wr, bus.flush, bus.jump_sel}, 6'b0);
    bus.op_call = 1'b0; bus.hold = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; m_sp = 16'h07FF; m_pend = 1'b0;
    run_op(0, 16'h0123, 3'b000, 0, 1'b0);
    chk("call_mem", mem[16'h07FF], 16'h0123);
    run_op(1, 16'h0000, 3'b000, 0, 1'b0);
    run_op(3, 16'h0040, 3'b101, 0, 1'b0);
    chk("int_mem", {mem[16'h07FF], mem[16'h07FE]}, {16'h0040, 16'h0005});
    run_op(2, 16'h0000, 3'b000, 0, 1'b0);
    run_op(1, 16'h0000, 3'b000, 0, 1'b1);
    run_op(3, 16'h0777, 3'b011, 0, 1'b0);
    run_op(2, 16'h0000, 3'b000, 0, 1'b0);
    run_op(3, 16'h0abc, 3'b110, 2, 1'b0);
    run_op(2, 16'h0000, 3'b000, 1, 1'b0);
    for (int n = 0; n < 120; n++) begin
      kind = int'($urandom_range(3));
      run_op(kind, 16'($urandom), 3'($urandom), 1, kind != 3 && $urandom_range(4) == 0);
    end
    if (m_pend) run_op(3, 16'($urandom), 3'($urandom), 0, 1'b0);
    do_reset();
    bus.interrupt = 1'b1;
    tick();
    bus.interrupt = 1'b0;
    m_pend = 1'b0;
    bus.op_reti = 1'b1;
    tick();
    bus.op_reti = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_fwr", bus.flags_wr, 1'b0);
    chk("mid_rst_state", {bus.busy, bus.pc_enable, bus.mem_re}, 3'b010);
    chk("mid_rst_sp", bus.sp, 16'h07FF);
    @(negedge clk);
    rst_n = 1'b1; m_sp = 16'h07FF;
    tick();
    chk("post_rst_busy", o_busy, 1'b0);
    for (int n = 0; n < 2047; n++) run_op(0, 16'($urandom), 3'b000, 0, 1'b0);
    chk("wrap_pre_sp", bus.sp, 16'h0000);
    run_op(0, 16'hbeef, 3'b000, 0, 1'b0);
    chk("wrap_sp", bus.sp, 16'hffff);
    run_op(1, 16'h0000, 3'b000, 0, 1'b0);
    chk("unwrap_sp", bus.sp, 16'h0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
